// File: rtl/instruction_fetch_stage.sv
// PC generator and fetch control in front of a 1-cycle synchronous text memory.
// Optional FETCH_FAULT_EN flags out-of-range or misaligned fetches and replaces them with NOP.
`ifndef TEXT_BEGIN
`define TEXT_BEGIN 32'h0040_0000
`endif
`ifndef TEXT_END
`define TEXT_END 32'h0FFF_FFFC
`endif

module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] TEXT_LO  = `TEXT_BEGIN,
  parameter logic [31:0] TEXT_HI  = `TEXT_END
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] text_address,
  input  logic [31:0] text_read_data,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst,
  output logic        inst_fault
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] f_pc;
  logic [31:0] d_pc;
  logic        d_valid;
  logic        advance;

  // An empty decode slot always advances, so a stall before the first word is ignored.
  assign advance = !stall || !d_valid;

  // A held cycle re-issues d_pc so text_read_data still matches it next cycle.
  assign text_address = redirect_valid ? redirect_target :
                        advance        ? f_pc            : d_pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f_pc    <= RESET_PC;
      d_pc    <= RESET_PC;
      d_valid <= 1'b0;
    end else if (redirect_valid) begin
      d_pc    <= redirect_target;
      d_valid <= 1'b1;
      f_pc    <= redirect_target + 32'd4;
    end else if (advance) begin
      d_pc    <= f_pc;
      d_valid <= 1'b1;
      f_pc    <= f_pc + 32'd4;
    end
  end

  assign inst_valid = d_valid;
  assign inst_pc    = d_pc;

`ifdef FETCH_FAULT_EN
  logic fault;
  assign fault      = d_valid && ((d_pc < TEXT_LO) || (d_pc > TEXT_HI) || (d_pc[1:0] != 2'b00));
  assign inst_fault = fault;
  assign inst       = (d_valid && !fault) ? text_read_data : NOP;
`else
  assign inst_fault = 1'b0;
  assign inst       = d_valid ? text_read_data : NOP;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Randomised bench for instruction_fetch_stage against a PC-sequence model of decode's view,
// with a synthetic text memory and a second instance exercising PC wraparound.
`ifndef TEXT_BEGIN
`define TEXT_BEGIN 32'h0040_0000
`endif
`ifndef TEXT_END
`define TEXT_END 32'h0FFF_FFFC
`endif

module tb_instruction_fetch_stage;
  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] LO  = `TEXT_BEGIN;
  localparam logic [31:0] HI  = `TEXT_END;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] text_address, text_read_data;
  logic        inst_valid, inst_fault;
  logic [31:0] inst_pc, inst;

  logic [31:0] w_address, w_pc, w_inst, w_rdata;
  logic        w_valid, w_fault;

  int checks = 0;
  int errors = 0;

  // Model of what decode should see: the word on display and the next sequential PC.
  logic [31:0] m_next, m_pc;
  logic        m_valid;

  always #5 clock = ~clock;

  instruction_fetch_stage #(.RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .text_address(text_address), .text_read_data(text_read_data),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .inst(inst), .inst_fault(inst_fault)
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clock(clock), .reset(reset), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .text_address(w_address), .text_read_data(w_rdata),
    .inst_valid(w_valid), .inst_pc(w_pc), .inst(w_inst), .inst_fault(w_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Synchronous-read text memory
  always @(posedge clock) begin
    text_read_data <= mem_word(text_address);
    w_rdata        <= 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_fault();
`ifdef FETCH_FAULT_EN
    return m_valid && ((m_pc < LO) || (m_pc > HI) || (m_pc[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_addr();
    if (reset) return RPC;
    if (redirect_valid) return redirect_target;
    if (!stall || !m_valid) return m_next;
    return m_pc;
  endfunction

  task automatic model_reset();
    m_next = RPC; m_pc = RPC; m_valid = 1'b0;
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] t);
    stall = s; redirect_valid = rv; redirect_target = t;
  endtask

  // Compare at negedge, then apply the cycle's effect on decode's view at posedge.
  task automatic tick();
    logic [31:0] a;
    @(negedge clock);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
    chk("inst_pc", inst_pc, m_pc);
    chk("inst", inst, (m_valid && !exp_fault()) ? mem_word(m_pc) : NOP);
    chk("inst_fault", {31'b0, inst_fault}, {31'b0, exp_fault()});
    a = exp_addr();
    chk("text_address", text_address, a);
    @(posedge clock);
    if (reset) model_reset();
    else if (redirect_valid || !stall || !m_valid) begin
      m_pc = a; m_valid = 1'b1; m_next = a + 32'd4;
    end
    #1;
  endtask

  initial begin
    logic [31:0] held_inst;
    logic [31:0] t;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_addr", text_address, RPC);
    chk("rst_pc", inst_pc, RPC);
    chk("rst_inst", inst, NOP);
    chk("rst_fault", {31'b0, inst_fault}, 32'd0);
    tick();
    reset = 1'b0;

    // Sequential fetch after release
    drive(0, 0, 0); #1;
    chk("t1_addr0", text_address, 32'h0040_0000);
    chk("t1_valid0", {31'b0, inst_valid}, 32'd0);
    chk("t6_addr0", w_address, 32'hFFFF_FFFC);
    tick();
    drive(0, 0, 0); #1;
    chk("t1_addr1", text_address, 32'h0040_0004);
    chk("t1_pc1", inst_pc, 32'h0040_0000);
    chk("t1_valid1", {31'b0, inst_valid}, 32'd1);
    chk("t6_addr1", w_address, 32'h0000_0000);
    chk("t6_pc1", w_pc, 32'hFFFF_FFFC);
    tick();
    drive(0, 0, 0); #1;
    chk("t1_addr2", text_address, 32'h0040_0008);
    chk("t1_pc2", inst_pc, 32'h0040_0004);
    chk("t6_pc2", w_pc, 32'h0000_0000);
    tick();

    // Hold for three cycles
    held_inst = inst;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0); #1;
      chk("t2_addr", text_address, 32'h0040_0008);
      chk("t2_pc", inst_pc, 32'h0040_0008);
      chk("t2_inst", inst, held_inst);
      tick();
    end
    drive(0, 0, 0); tick();
    drive(0, 0, 0); #1;
    chk("t2_after", inst_pc, 32'h0040_000C);
    tick();

    // Redirect wins over stall
    drive(1, 1, 32'h0040_0100); #1;
    chk("t3_addr", text_address, 32'h0040_0100);
    tick();
    drive(0, 0, 0); #1;
    chk("t3_valid", {31'b0, inst_valid}, 32'd1);
    chk("t3_pc", inst_pc, 32'h0040_0100);
    chk("t3_addr_next", text_address, 32'h0040_0104);
    tick();

    // Misaligned and out-of-range redirects
    drive(0, 1, 32'h0040_0102); tick();
    drive(0, 0, 0); #1;
    chk("t5_pc_mis", inst_pc, 32'h0040_0102);
    tick();
    drive(0, 1, HI + 32'd4); tick();
    drive(0, 0, 0); tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      t = LO + ($urandom_range(0, 1023) << 2);
      if ($urandom_range(0, 7) == 0) t = t + $urandom_range(1, 3);
      if ($urandom_range(0, 15) == 0) t = HI + 32'd4;
      drive($urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0, t);
      tick();
    end

    // Asynchronous reset between edges
    drive(1, 0, 0);
    #3 reset = 1'b1;
    #1;
    chk("t4_valid", {31'b0, inst_valid}, 32'd0);
    chk("t4_addr", text_address, 32'h0040_0000);
    chk("t4_pc", inst_pc, 32'h0040_0000);
    chk("t4_inst", inst, NOP);
    model_reset();
    tick();
    reset = 1'b0;

    // Stall in the first post-reset cycle is ignored
    drive(1, 0, 0); #1;
    chk("t4_addr0", text_address, 32'h0040_0000);
    tick();
    drive(0, 0, 0); #1;
    chk("t4_valid1", {31'b0, inst_valid}, 32'd1);
    chk("t4_pc1", inst_pc, 32'h0040_0000);
    chk("t4_addr1", text_address, 32'h0040_0004);
    tick();
    for (int i = 0; i < 100; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 7) == 0, LO + ($urandom_range(0, 255) << 2));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
